// File: rtl/fixed_point_accumulator.sv
// Streaming sign-magnitude accumulator: sums COUNT operands per frame and emits
// the saturated sum (or rounded mean) over a valid/ready output handshake.
module fixed_point_accumulator #(
   parameter int N     = 8,
   parameter int COUNT = 4,
   parameter int AVG   = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_sat
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both
   // high; out_valid/out_data/out_sat stay stable until that edge.
   localparam int LG   = $clog2(COUNT);
   localparam int AW   = N + LG;
   localparam int CW   = (LG < 1) ? 1 : LG;
   localparam int MAXM = (2 ** (N - 1)) - 1;

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t state, state_next;

   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic [AW-1:0] op_mag, operand, sum, sum_abs, res_mag;
   logic [N-2:0]  res_field;
   logic          res_sign, res_sat;
   logic          accept, last;

   assign in_ready = rst_n & (state == ST_ACC) & ~clear;
   assign accept   = in_valid & in_ready;
   assign last     = (cnt == CW'(COUNT - 1));

   always_comb begin
      op_mag  = AW'(in_data[N-2:0]);
      operand = in_data[N-1] ? -op_mag : op_mag;
      sum     = acc + operand;
      sum_abs = sum[AW-1] ? -sum : sum;
      // Adding COUNT/2 before the shift rounds the magnitude half away from zero.
      if (AVG != 0) res_mag = (sum_abs + AW'(COUNT / 2)) >> LG;
      else          res_mag = sum_abs;
      res_sat   = (res_mag > AW'(MAXM));
      res_field = res_sat ? '1 : res_mag[N-2:0];
      res_sign  = sum[AW-1] & (res_mag != '0);
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_ACC:  if (accept && last) state_next = ST_OUT;
         ST_OUT:  if (out_ready)      state_next = ST_ACC;
         default: state_next = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_ACC;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (clear) begin
                  acc <= '0;
                  cnt <= '0;
               end else if (accept) begin
                  acc <= sum;
                  if (last) begin
                     cnt       <= '0;
                     out_data  <= {res_sign, res_field};
                     out_sat   <= res_sat;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Drives one stream into a sum (AVG=0) and a mean (AVG=1) accumulator and
// scores both against an integer-arithmetic reference model.
module tb_fixed_point_accumulator;

   localparam int N     = 8;
   localparam int COUNT = 4;
   localparam int MAXM  = (2 ** (N - 1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         out_ready = 1'b1;
   logic         in_ready_s, out_valid_s, out_sat_s;
   logic         in_ready_a, out_valid_a, out_sat_a;
   logic [N-1:0] out_data_s, out_data_a;

   int  checks = 0;
   int  failures = 0;
   bit  rand_bp = 1'b0;

   logic [N:0] exp_q_sum[$];
   logic [N:0] exp_q_avg[$];
   int         frame_q[$];

   fixed_point_accumulator #(.N(N), .COUNT(COUNT), .AVG(0)) u_sum (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s));

   fixed_point_accumulator #(.N(N), .COUNT(COUNT), .AVG(1)) u_avg (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer sum of the frame, optional rounded mean, then
   // saturation into sign-magnitude with zero forced positive.
   function automatic logic [N:0] ref_result(input int s, input bit avg);
      int m;
      bit neg;
      bit sat;
      logic [N-2:0] field;
      neg = (s < 0);
      m   = neg ? -s : s;
      if (avg) m = (m + COUNT / 2) / COUNT;
      sat = (m > MAXM);
      if (sat) m = MAXM;
      field = m[N-2:0];
      return {sat, (neg && m != 0), field};
   endfunction

   function automatic int sm_value(input logic [N-1:0] d);
      int mag;
      mag = int'(d[N-2:0]);
      return d[N-1] ? -mag : mag;
   endfunction

   task automatic model_accept(input logic [N-1:0] d);
      int s;
      frame_q.push_back(sm_value(d));
      if (frame_q.size() == COUNT) begin
         s = 0;
         foreach (frame_q[i]) s += frame_q[i];
         exp_q_sum.push_back(ref_result(s, 1'b0));
         exp_q_avg.push_back(ref_result(s, 1'b1));
         frame_q.delete();
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [N-1:0] d);
      int tries;
      in_valid = 1'b1;
      in_data  = d;
      tries    = 0;
      #1;
      while (!in_ready_s && tries < 100) begin
         tick();
         #1;
         tries++;
      end
      if (!in_ready_s) begin
         check("send_timeout", 32'(in_ready_s), 32'd1);
      end else begin
         model_accept(d);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] c, input logic [N-1:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_q.delete();
      exp_q_sum.delete();
      exp_q_avg.delete();
      tick();
      check("rst_out_valid_s", 32'(out_valid_s), 32'd0);
      check("rst_out_data_s",  32'(out_data_s),  32'd0);
      check("rst_out_sat_s",   32'(out_sat_s),   32'd0);
      check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
      check("rst_out_data_a",  32'(out_data_a),  32'd0);
      check("rst_in_ready",    32'(in_ready_s | in_ready_a), 32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: sampled after the drivers settle each negedge; pops on handshake
   // and checks that a stalled result does not move.
   bit         pend[2];
   logic [N:0] held[2];

   always @(negedge clk) begin
      logic       v;
      logic [N:0] obs;
      logic [N:0] exp;
      #2;
      for (int k = 0; k < 2; k++) begin
         v   = (k == 0) ? out_valid_s : out_valid_a;
         obs = (k == 0) ? {out_sat_s, out_data_s} : {out_sat_a, out_data_a};
         if (!rst_n) begin
            pend[k] = 1'b0;
         end else begin
            if (pend[k]) begin
               check((k == 0) ? "hold_valid_sum" : "hold_valid_avg", 32'(v), 32'd1);
               if (v) check((k == 0) ? "hold_data_sum" : "hold_data_avg", 32'(obs), 32'(held[k]));
            end
            pend[k] = 1'b0;
            if (v && out_ready) begin
               if (((k == 0) ? exp_q_sum.size() : exp_q_avg.size()) == 0) begin
                  check((k == 0) ? "unexpected_sum" : "unexpected_avg", 32'(obs), 32'h1ff);
               end else begin
                  exp = (k == 0) ? exp_q_sum.pop_front() : exp_q_avg.pop_front();
                  check((k == 0) ? "result_sum" : "result_avg", 32'(obs), 32'(exp));
               end
            end else if (v) begin
               pend[k] = 1'b1;
               held[k] = obs;
            end
         end
      end
   end

   initial begin
      logic [N-1:0] r[4];
      int n;
      repeat (3) tick();
      do_reset();
      check("idle_in_ready", 32'(in_ready_s & in_ready_a), 32'd1);

      // Sum, with output latency and single-cycle valid.
      send_frame(8'h05, 8'h05, 8'h05, 8'h05);
      check("lat_valid_rise_s", 32'(out_valid_s), 32'd1);
      check("lat_valid_rise_a", 32'(out_valid_a), 32'd1);
      tick();
      check("lat_valid_fall_s", 32'(out_valid_s), 32'd0);

      // Mixed signs, saturation, averaging vectors.
      send_frame(8'h10, 8'h83, 8'h01, 8'h82);
      send_frame(8'h85, 8'h01, 8'h80, 8'h80);
      send_frame(8'h05, 8'h85, 8'h00, 8'h80);
      send_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F);
      send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      send_frame(8'h7F, 8'h01, 8'h00, 8'h00);
      send_frame(8'h05, 8'h06, 8'h06, 8'h06);
      send_frame(8'h85, 8'h86, 8'h86, 8'h86);

      // Backpressure, with a clear pulse that must be ignored in OUT.
      tick();
      out_ready = 1'b0;
      send_frame(8'h10, 8'h83, 8'h01, 8'h82);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h33;
         clear    = (i == 2);
         #1;
         check("bp_in_ready", 32'(in_ready_s | in_ready_a), 32'd0);
         check("bp_out_valid", 32'(out_valid_s & out_valid_a), 32'd1);
         tick();
      end
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      tick();
      send_frame(8'h05, 8'h05, 8'h05, 8'h05);

      // Abort a partial frame with clear.
      send(8'h11);
      send(8'h22);
      clear = 1'b1;
      frame_q.delete();
      #1;
      check("clear_in_ready", 32'(in_ready_s | in_ready_a), 32'd0);
      tick();
      clear = 1'b0;
      send_frame(8'h01, 8'h01, 8'h01, 8'h01);
      tick();

      // Reset mid-frame, then mid-OUT.
      send(8'h11);
      send(8'h22);
      do_reset();
      send_frame(8'h05, 8'h05, 8'h05, 8'h05);
      tick();
      out_ready = 1'b0;
      send_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F);
      check("pre_rst_valid", 32'(out_valid_s), 32'd1);
      do_reset();
      out_ready = 1'b1;
      send_frame(8'h10, 8'h83, 8'h01, 8'h82);

      // Random frames with random gaps, backpressure and occasional aborts.
      rand_bp = 1'b1;
      for (int f = 0; f < 40; f++) begin
         for (int j = 0; j < 4; j++) r[j] = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(1, COUNT - 1);
            for (int j = 0; j < n; j++) send(r[j]);
            clear = 1'b1;
            frame_q.delete();
            tick();
            clear = 1'b0;
         end
         for (int j = 0; j < 4; j++) begin
            send(r[j]);
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      rand_bp   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (exp_q_sum.size() + exp_q_avg.size()) != 0; i++) tick();
      tick();
      check("drain_sum", 32'(exp_q_sum.size()), 32'd0);
      check("drain_avg", 32'(exp_q_avg.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
